// File: rtl/seg_disp_pkg.sv
// Shared character map for the multiplexed 7-segment drivers.
// Holds the character-code constants and the active-high segment patterns
// in {g,f,e,d,c,b,a} order.
package seg_disp_pkg;

  localparam int CHAR_W = 5;

  typedef logic [6:0] seg_pattern_t;
  typedef logic [CHAR_W-1:0] char_code_t;

  localparam char_code_t CH_0     = 5'd0;
  localparam char_code_t CH_1     = 5'd1;
  localparam char_code_t CH_2     = 5'd2;
  localparam char_code_t CH_3     = 5'd3;
  localparam char_code_t CH_4     = 5'd4;
  localparam char_code_t CH_5     = 5'd5;
  localparam char_code_t CH_6     = 5'd6;
  localparam char_code_t CH_7     = 5'd7;
  localparam char_code_t CH_8     = 5'd8;
  localparam char_code_t CH_9     = 5'd9;
  localparam char_code_t CH_DASH  = 5'd10;
  localparam char_code_t CH_E     = 5'd11;
  localparam char_code_t CH_R     = 5'd12;
  localparam char_code_t CH_L     = 5'd13;
  localparam char_code_t CH_H     = 5'd14;
  localparam char_code_t CH_U     = 5'd15;
  localparam char_code_t CH_P     = 5'd16;
  localparam char_code_t CH_O     = 5'd17;
  localparam char_code_t CH_B     = 5'd18;
  localparam char_code_t CH_D     = 5'd19;
  localparam char_code_t CH_N     = 5'd20;
  localparam char_code_t CH_J     = 5'd21;
  localparam char_code_t CH_Y     = 5'd22;
  localparam char_code_t CH_H_LC  = 5'd30;
  localparam char_code_t CH_BLANK = 5'd31;

  // Active-high pattern table; codes without a glyph (23..29) stay dark.
  function automatic seg_pattern_t char_pattern(input char_code_t code);
    seg_pattern_t pat;
    pat = 7'h00;
    case (code)
      CH_0:     pat = 7'h3F;
      CH_1:     pat = 7'h06;
      CH_2:     pat = 7'h5B;
      CH_3:     pat = 7'h4F;
      CH_4:     pat = 7'h66;
      CH_5:     pat = 7'h6D;
      CH_6:     pat = 7'h7D;
      CH_7:     pat = 7'h07;
      CH_8:     pat = 7'h7F;
      CH_9:     pat = 7'h6F;
      CH_DASH:  pat = 7'h40;
      CH_E:     pat = 7'h79;
      CH_R:     pat = 7'h50;
      CH_L:     pat = 7'h38;
      CH_H:     pat = 7'h76;
      CH_U:     pat = 7'h3E;
      CH_P:     pat = 7'h73;
      CH_O:     pat = 7'h5C;
      CH_B:     pat = 7'h7C;
      CH_D:     pat = 7'h5E;
      CH_N:     pat = 7'h54;
      CH_J:     pat = 7'h1E;
      CH_Y:     pat = 7'h6E;
      CH_H_LC:  pat = 7'h74;
      CH_BLANK: pat = 7'h00;
      default:  pat = 7'h00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_mux_display_n_decoder.sv
// Combinational character-code to segment-pattern lookup.
// Output is active-high; the parent applies board polarity.
module seg7_char_decoder
  import seg_disp_pkg::*;
(
  input  logic [CHAR_W-1:0] code,
  output logic [6:0]        pattern
);

  assign pattern = char_pattern(code);

endmodule

// File: rtl/seg_mux_display_n.sv
// Time-multiplexed N-digit 7-segment driver with double-buffered loading,
// PWM brightness, per-digit blink, an inter-digit blanking gap and
// selectable anode/segment polarity. All pin outputs are registered.
module seg_mux_display_n
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CHAR_W_P       = CHAR_W,
  parameter int SLOT_CYC       = 32768,
  parameter int BLANK_CYC      = 64,
  parameter int BRIGHT_W       = 3,
  parameter int BLINK_FRAMES   = 256,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic [NUM_DIGITS*CHAR_W-1:0] char_data,
  input  logic [NUM_DIGITS-1:0]        dp_data,
  input  logic [NUM_DIGITS-1:0]        blink_mask,
  input  logic [BRIGHT_W-1:0]          brightness,
  output logic [6:0]                   seg,
  output logic                         dp,
  output logic [NUM_DIGITS-1:0]        an,
  output logic                         frame_tick
);

  localparam int SLOT_W  = $clog2(SLOT_CYC);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_CYC - 1);
  localparam logic [SLOT_W-1:0]  BLANK_END  = SLOT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  // XOR masks that turn active-high internal values into pin polarity.
  localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
  localparam logic [6:0]            SEG_INV = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);

  // Scan state
  logic [SLOT_W-1:0]  slot_cnt_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               blink_phase_reg;

  // Shadow (written by load) and active (displayed) buffers
  logic                         pending_reg;
  logic [NUM_DIGITS*CHAR_W-1:0] shd_char_reg;
  logic [NUM_DIGITS-1:0]        shd_dp_reg;
  logic [NUM_DIGITS-1:0]        shd_blink_reg;
  logic [BRIGHT_W-1:0]          shd_bright_reg;
  logic [NUM_DIGITS*CHAR_W-1:0] act_char_reg;
  logic [NUM_DIGITS-1:0]        act_dp_reg;
  logic [NUM_DIGITS-1:0]        act_blink_reg;
  logic [BRIGHT_W-1:0]          act_bright_reg;

  // Registered pin drivers
  logic [NUM_DIGITS-1:0] an_reg;
  logic [6:0]            seg_reg;
  logic                  dp_reg;
  logic                  frame_tick_reg;

  logic                  slot_wrap;
  logic                  frame_end;
  logic                  lit;
  logic [CHAR_W-1:0]     cur_char;
  logic [6:0]            cur_pattern;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic [CHAR_W-1:0]     act_char_arr [NUM_DIGITS];

  assign slot_wrap = (slot_cnt_reg == SLOT_LAST);
  assign frame_end = slot_wrap && (idx_reg == '0);

  // Unpack the active characters and build the one-hot digit select.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign act_char_arr[gi] = act_char_reg[gi*CHAR_W +: CHAR_W];
    assign digit_sel[gi]    = (idx_reg == IDX_W'(gi));
  end

  assign cur_char = act_char_arr[idx_reg];

  seg7_char_decoder u_decoder (
    .code    (cur_char),
    .pattern (cur_pattern)
  );

  // Slot lit when past the blanking gap, inside the PWM window and not blinked off.
  assign lit = (slot_cnt_reg >= BLANK_END)
            && (slot_cnt_reg[SLOT_W-1 -: BRIGHT_W] <= act_bright_reg)
            && !(act_blink_reg[idx_reg] && blink_phase_reg);

  // Slot counter and digit index: leftmost digit first, wrapping after digit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt_reg <= '0;
      idx_reg      <= IDX_LAST;
    end else begin
      slot_cnt_reg <= slot_cnt_reg + 1'b1;
      if (slot_wrap) begin
        idx_reg <= (idx_reg == '0) ? IDX_LAST : idx_reg - 1'b1;
      end
    end
  end

  // Blink phase toggles once every BLINK_FRAMES completed frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  // Shadow capture on load; a load on the boundary cycle still marks pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg    <= 1'b0;
      shd_char_reg   <= '0;
      shd_dp_reg     <= '0;
      shd_blink_reg  <= '0;
      shd_bright_reg <= '0;
    end else if (load) begin
      pending_reg    <= 1'b1;
      shd_char_reg   <= char_data;
      shd_dp_reg     <= dp_data;
      shd_blink_reg  <= blink_mask;
      shd_bright_reg <= brightness;
    end else if (frame_end) begin
      pending_reg <= 1'b0;
    end
  end

  // Active buffer only changes at a frame boundary so every frame shows one load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_char_reg   <= {NUM_DIGITS{CH_BLANK}};
      act_dp_reg     <= '0;
      act_blink_reg  <= '0;
      act_bright_reg <= '0;
    end else if (frame_end && pending_reg) begin
      act_char_reg   <= shd_char_reg;
      act_dp_reg     <= shd_dp_reg;
      act_blink_reg  <= shd_blink_reg;
      act_bright_reg <= shd_bright_reg;
    end
  end

  // Pin registers: anodes, segments and dp all update on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_reg         <= AN_INV;
      seg_reg        <= SEG_INV;
      dp_reg         <= DP_INV;
      frame_tick_reg <= 1'b0;
    end else begin
      an_reg         <= (lit ? digit_sel : '0) ^ AN_INV;
      seg_reg        <= (lit ? cur_pattern : 7'h00) ^ SEG_INV;
      dp_reg         <= (lit && act_dp_reg[idx_reg]) ^ DP_INV;
      frame_tick_reg <= frame_end;
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign frame_tick = frame_tick_reg;

endmodule
